// File: rtl/jk_exciter.sv
// rtl/jk_exciter.sv - JK flip-flop bank excitation controller with drive/check/retry sequencing
// Optional post-drive verification and retry enabled by JK_EXCITER_VERIFY_EN.
module jk_exciter #(
  parameter int WIDTH     = 4,
  parameter int CHECK_LAT = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             done_err,
  output logic [WIDTH-1:0] err_mask,
  output logic [3:0]       retry_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, RESP} state_t;

  if (CHECK_LAT < 1 || MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_param
    $error("jk_exciter: CHECK_LAT must be >= 1 and MAX_RETRY 0..15");
  end

`ifdef JK_EXCITER_VERIFY_EN
  localparam int     WAIT_LEN   = CHECK_LAT - 1;
  localparam state_t AFTER_WAIT = CHECK;
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
`else
  // Without verification the slot CHECK would occupy becomes one more wait
  // cycle, so completion latency matches the verified success case.
  localparam int     WAIT_LEN   = CHECK_LAT;
  localparam state_t AFTER_WAIT = RESP;
`endif
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LEN - 1);

  state_t           state;
  logic [WIDTH-1:0] tgt_reg;
  logic [15:0]      wait_cnt;

`ifdef JK_EXCITER_VERIFY_EN
  logic             err_q;
  logic [WIDTH-1:0] mask_q;
  logic [3:0]       retry_q;
  logic [WIDTH-1:0] mask;

  assign mask      = tgt_reg ^ q_fb;
  assign done_err  = err_q;
  assign err_mask  = mask_q;
  assign retry_cnt = retry_q;
`else
  assign done_err  = 1'b0;
  assign err_mask  = '0;
  assign retry_cnt = 4'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tgt_reg  <= '0;
      wait_cnt <= '0;
`ifdef JK_EXCITER_VERIFY_EN
      err_q    <= 1'b0;
      mask_q   <= '0;
      retry_q  <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_reg <= tgt_data;
            state   <= DRIVE;
`ifdef JK_EXCITER_VERIFY_EN
            retry_q <= 4'd0;
            err_q   <= 1'b0;
            mask_q  <= '0;
`endif
          end
        end
        DRIVE: begin
          wait_cnt <= '0;
          state    <= (WAIT_LEN == 0) ? AFTER_WAIT : WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= AFTER_WAIT;
          else wait_cnt <= wait_cnt + 16'd1;
        end
`ifdef JK_EXCITER_VERIFY_EN
        CHECK: begin
          mask_q <= mask;
          if (mask == '0) begin
            err_q <= 1'b0;
            state <= RESP;
          end else if (retry_q < RETRY_MAX) begin
            retry_q <= retry_q + 4'd1;
            state   <= DRIVE;
          end else begin
            err_q <= 1'b1;
            state <= RESP;
          end
        end
`endif
        RESP: begin
          if (done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Excitation follows q_fb live during DRIVE; the bank samples it at the drive edge.
  assign j_out      = (state == DRIVE) ? (tgt_reg & ~q_fb) : '0;
  assign k_out      = (state == DRIVE) ? (~tgt_reg & q_fb) : '0;
  assign tgt_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done_valid = (state == RESP);

endmodule

// File: tb/tb_jk_exciter.sv
// tb/tb_jk_exciter.sv - directed self-checking bench for jk_exciter with a JK bank model
module tb_jk_exciter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [3:0] tgt_data = 4'd0;
  logic [3:0] q_bank = 4'd0;
  logic [3:0] j_out, k_out;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic       done_err;
  logic [3:0] err_mask;
  logic [3:0] retry_cnt;
  logic       busy;

  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'd0;
  logic [3:0] stuck0 = 4'd0;

  int errors = 0;
  int checks = 0;
  int edges, drives;

`ifdef JK_EXCITER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  jk_exciter #(.WIDTH(4), .CHECK_LAT(1), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_data(tgt_data),
    .q_fb(q_bank), .j_out(j_out), .k_out(k_out),
    .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err),
    .err_mask(err_mask), .retry_cnt(retry_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // JK bank model; stuck0 bits are forced low after every update.
  always @(posedge clk) begin
    if (force_en) q_bank <= force_val;
    else q_bank <= ((j_out & ~q_bank) | (~k_out & q_bank)) & ~stuck0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load_bank(input logic [3:0] v);
    @(negedge clk);
    force_en = 1'b1; force_val = v;
    @(posedge clk); #1;
    force_en = 1'b0;
  endtask

  task automatic accept(input logic [3:0] d);
    @(negedge clk);
    tgt_valid = 1'b1; tgt_data = d;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
  endtask

  task automatic wait_done();
    edges = 0; drives = 0;
    while (!done_valid && edges < 40) begin
      if (j_out != 4'd0 || k_out != 4'd0) drives++;
      @(posedge clk); #1;
      edges++;
    end
    check("done_timeout", done_valid, 1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_tgt_ready", tgt_ready, 1'b1);
    check("rst_j", j_out, 4'd0);
    check("rst_k", k_out, 4'd0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_done_err", done_err, 1'b0);
    check("rst_err_mask", err_mask, 4'd0);
    check("rst_retry", retry_cnt, 4'd0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Set path, done_ready held high so RESP exits in its first cycle
    load_bank(4'b0000);
    done_ready = 1'b1;
    accept(4'b1010);
    check("set_j", j_out, 4'b1010);
    check("set_k", k_out, 4'b0000);
    check("set_busy", busy, 1'b1);
    check("set_tgt_ready", tgt_ready, 1'b0);
    wait_done();
    check("set_latency", edges, 2);
    check("set_err", done_err, 1'b0);
    check("set_retry", retry_cnt, 4'd0);
    check("set_mask", err_mask, 4'd0);
    check("set_bank", q_bank, 4'b1010);
    @(posedge clk); #1;
    check("set_idle_valid", done_valid, 1'b0);
    check("set_idle_ready", tgt_ready, 1'b1);

    // Reset path
    load_bank(4'b1111);
    accept(4'b0101);
    check("rp_j", j_out, 4'b0000);
    check("rp_k", k_out, 4'b1010);
    wait_done();
    check("rp_latency", edges, 2);
    check("rp_err", done_err, 1'b0);
    check("rp_bank", q_bank, 4'b0101);
    @(posedge clk); #1;

    // Stuck bit 0, then backpressure on the result
    done_ready = 1'b0;
    stuck0 = 4'b0001;
    load_bank(4'b0000);
    accept(4'b0001);
    check("stk_j", j_out, 4'b0001);
    check("stk_k", k_out, 4'b0000);
    wait_done();
    check("stk_drives", drives, VERIFY ? 3 : 1);
    check("stk_latency", edges, VERIFY ? 6 : 2);
    check("stk_err", done_err, VERIFY ? 1'b1 : 1'b0);
    check("stk_mask", err_mask, VERIFY ? 4'b0001 : 4'b0000);
    check("stk_retry", retry_cnt, VERIFY ? 4'd2 : 4'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tgt_valid = (i == 2); tgt_data = 4'b1111;
      @(posedge clk); #1;
      check("bp_valid", done_valid, 1'b1);
      check("bp_err", done_err, VERIFY ? 1'b1 : 1'b0);
      check("bp_mask", err_mask, VERIFY ? 4'b0001 : 4'b0000);
      check("bp_retry", retry_cnt, VERIFY ? 4'd2 : 4'd0);
      check("bp_tgt_ready", tgt_ready, 1'b0);
      check("bp_j", j_out, 4'd0);
    end
    @(negedge clk);
    tgt_valid = 1'b0; done_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_exit_valid", done_valid, 1'b0);
    check("bp_exit_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("bp_no_accept", busy, 1'b0);
    stuck0 = 4'b0000;

    // Asynchronous reset during DRIVE
    load_bank(4'b0000);
    accept(4'b1100);
    check("mr_drive_j", j_out, 4'b1100);
    rst = 1'b0; #1;
    check("mr_j", j_out, 4'd0);
    check("mr_k", k_out, 4'd0);
    check("mr_busy", busy, 1'b0);
    check("mr_tgt_ready", tgt_ready, 1'b1);
    check("mr_done_valid", done_valid, 1'b0);
    @(negedge clk); rst = 1'b1;
    check("mr_bank_kept", q_bank, 4'b0000);

    // Recovery after reset
    accept(4'b0110);
    check("rc_j", j_out, 4'b0110);
    check("rc_k", k_out, 4'b0000);
    wait_done();
    check("rc_latency", edges, 2);
    check("rc_err", done_err, 1'b0);
    check("rc_bank", q_bank, 4'b0110);
    @(posedge clk); #1;
    check("rc_idle", tgt_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
